// File: rtl/calc_pkg.sv
// Shared types and constants for the two-digit BCD calculator front end.
package calc_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_W   = 8;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned KEY_W   = 4;

    typedef enum logic [1:0] {
        S_OP1    = 2'd0,
        S_OP2    = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    localparam logic [KEY_W-1:0] KEY_ADD = 4'hA;
    localparam logic [KEY_W-1:0] KEY_SUB = 4'hB;
    localparam logic [KEY_W-1:0] KEY_EQ  = 4'hC;
    localparam logic [KEY_W-1:0] KEY_CLR = 4'hD;

    // The ALU uses opcode[1] as its subtract select.
    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b010;

    typedef enum logic [2:0] {
        KC_NONE  = 3'd0,
        KC_DIGIT = 3'd1,
        KC_OPER  = 3'd2,
        KC_EQ    = 3'd3,
        KC_CLR   = 3'd4
    } key_class_t;

    typedef struct packed {
        logic [BCD_W-1:0] value;
        logic             carry;
    } result_t;

    function automatic key_class_t classify_key(input logic valid, input logic [KEY_W-1:0] code);
        key_class_t kc;
        kc = KC_NONE;
        if (valid) begin
            if (code <= 4'd9)                          kc = KC_DIGIT;
            else if (code == KEY_ADD || code == KEY_SUB) kc = KC_OPER;
            else if (code == KEY_EQ)                   kc = KC_EQ;
            else if (code == KEY_CLR)                  kc = KC_CLR;
            else                                       kc = KC_NONE;
        end
        return kc;
    endfunction

    function automatic logic [OPC_W-1:0] key_opcode(input logic [KEY_W-1:0] code);
        return (code == KEY_SUB) ? OP_SUB : OP_ADD;
    endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// Multi-digit BCD entry register: shifts digits in from the right until full,
// with a synchronous clear and a parallel load that also sets the digit count.
module bcd_shift_reg
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr_i,
    input  logic                              shift_i,
    input  logic [DIGIT_W-1:0]                digit_i,
    input  logic                              load_i,
    input  logic [DIGITS*DIGIT_W-1:0]         load_val_i,
    input  logic [$clog2(DIGITS+1)-1:0]       load_cnt_i,
    output logic [DIGITS*DIGIT_W-1:0]         value_o,
    output logic                              full_o
);

    localparam int unsigned VAL_W = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);

    logic [VAL_W-1:0] value_q, value_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q;

    // Clear beats load beats shift; a shift into a full register is dropped.
    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (load_i) begin
            value_d = load_val_i;
            cnt_d   = load_cnt_i;
        end else if (shift_i && !full_q) begin
            value_d = {value_q[VAL_W-DIGIT_W-1:0], digit_i};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DIGITS));
        end
    end

    assign value_o = value_q;
    assign full_o  = full_q;

endmodule

// File: rtl/bcd_operand_entry.sv
// Keypad-to-ALU front end: assembles two BCD operands and an opcode from key
// strobes, captures the ALU result on equals and selects the display value.
module bcd_operand_entry
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_code,
    input  logic [BCD_W-1:0]  alu_result,
    input  logic              alu_carry,
    output logic [BCD_W-1:0]  op1,
    output logic [BCD_W-1:0]  op2,
    output logic [OPC_W-1:0]  opcode,
    output logic [BCD_W-1:0]  result,
    output logic              carry,
    output logic              result_valid,
    output logic [BCD_W-1:0]  display,
    output logic [1:0]        state
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    result_t          res_q, res_d;
    logic             result_valid_q;
    key_class_t       kc;

    logic             op1_clr, op1_shift, op1_load, op1_full;
    logic [BCD_W-1:0] op1_load_val;
    logic [CNT_W-1:0] op1_load_cnt;
    logic             op2_clr, op2_shift, op2_full;
    logic [BCD_W-1:0] op1_val, op2_val;

    assign kc = classify_key(key_valid, key_code);

    bcd_shift_reg #(.DIGITS(MAX_DIGITS)) u_op1 (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (op1_clr),
        .shift_i    (op1_shift),
        .digit_i    (key_code),
        .load_i     (op1_load),
        .load_val_i (op1_load_val),
        .load_cnt_i (op1_load_cnt),
        .value_o    (op1_val),
        .full_o     (op1_full)
    );

    bcd_shift_reg #(.DIGITS(MAX_DIGITS)) u_op2 (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (op2_clr),
        .shift_i    (op2_shift),
        .digit_i    (key_code),
        .load_i     (1'b0),
        .load_val_i ('0),
        .load_cnt_i ('0),
        .value_o    (op2_val),
        .full_o     (op2_full)
    );

    // Next-state and operand-register control.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        res_d        = res_q;
        op1_clr      = 1'b0;
        op1_shift    = 1'b0;
        op1_load     = 1'b0;
        op1_load_val = '0;
        op1_load_cnt = '0;
        op2_clr      = 1'b0;
        op2_shift    = 1'b0;

        if (kc == KC_CLR) begin
            state_d  = S_OP1;
            opcode_d = OP_ADD;
            res_d    = '0;
            op1_clr  = 1'b1;
            op2_clr  = 1'b1;
        end else begin
            case (state_q)
                S_OP1: begin
                    case (kc)
                        KC_DIGIT: op1_shift = 1'b1;
                        KC_OPER: begin
                            opcode_d = key_opcode(key_code);
                            op2_clr  = 1'b1;
                            state_d  = S_OP2;
                        end
                        default: ;
                    endcase
                end
                S_OP2: begin
                    case (kc)
                        KC_DIGIT: op2_shift = 1'b1;
                        KC_OPER:  opcode_d  = key_opcode(key_code);
                        KC_EQ: begin
                            res_d   = '{value: alu_result, carry: alu_carry};
                            state_d = S_RESULT;
                        end
                        default: ;
                    endcase
                end
                S_RESULT: begin
                    case (kc)
                        KC_DIGIT: begin
                            op1_load     = 1'b1;
                            op1_load_val = {4'h0, key_code};
                            op1_load_cnt = CNT_W'(1);
                            op2_clr      = 1'b1;
                            state_d      = S_OP1;
                        end
                        KC_OPER: begin
                            // Chained operand 1 is marked full so it cannot be extended.
                            op1_load     = 1'b1;
                            op1_load_val = res_q.value;
                            op1_load_cnt = CNT_W'(MAX_DIGITS);
                            op2_clr      = 1'b1;
                            opcode_d     = key_opcode(key_code);
                            state_d      = S_OP2;
                        end
                        default: ;
                    endcase
                end
                default: state_d = S_OP1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_OP1;
            opcode_q       <= OP_ADD;
            res_q          <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            res_q          <= res_d;
            result_valid_q <= (state_d == S_RESULT);
        end
    end

    // Display follows the registered state.
    always_comb begin
        display = '0;
        case (state_q)
            S_OP1:    display = op1_val;
            S_OP2:    display = op2_val;
            S_RESULT: display = res_q.value;
            default:  display = '0;
        endcase
    end

    assign op1          = op1_val;
    assign op2          = op2_val;
    assign opcode       = opcode_q;
    assign result       = res_q.value;
    assign carry        = res_q.carry;
    assign result_valid = result_valid_q;
    assign state        = state_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Scoreboard bench for bcd_operand_entry with a stubbed ALU.
module tb_bcd_operand_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [7:0] alu_result = 8'h00;
    logic       alu_carry = 1'b0;

    logic [7:0] op1, op2, result, display;
    logic [2:0] opcode;
    logic       carry, result_valid;
    logic [1:0] state;

    bcd_operand_entry dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .op1          (op1),
        .op2          (op2),
        .opcode       (opcode),
        .result       (result),
        .carry        (carry),
        .result_valid (result_valid),
        .display      (display),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [2:0] opc;
        logic [7:0] res;
        logic       car;
        logic       rv;
        logic [7:0] disp;
        logic [1:0] st;
    } snap_t;

    snap_t sb[$];
    snap_t exp_s;
    int    n_vec = 0;
    int    n_err = 0;
    logic  apply = 1'b0;
    logic  pend  = 1'b0;

    // Reference model state
    logic [7:0] m_op1 = 8'h00, m_op2 = 8'h00, m_res = 8'h00;
    logic [2:0] m_opc = 3'b000;
    logic       m_car = 1'b0;
    logic [1:0] m_st  = 2'd0;
    int         m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_op1 = 8'h00; m_op2 = 8'h00; m_res = 8'h00;
        m_opc = 3'b000; m_car = 1'b0; m_st = 2'd0; m_cnt = 0;
    endtask

    task automatic m_step(input logic r, input logic kv, input logic [3:0] k);
        if (r || (kv && k == 4'hD)) begin
            m_reset();
        end else if (kv) begin
            if (k <= 4'd9) begin
                if (m_st == 2'd0 && m_cnt < 2) begin
                    m_op1 = {m_op1[3:0], k}; m_cnt++;
                end else if (m_st == 2'd1 && m_cnt < 2) begin
                    m_op2 = {m_op2[3:0], k}; m_cnt++;
                end else if (m_st == 2'd2) begin
                    m_op1 = {4'h0, k}; m_op2 = 8'h00; m_cnt = 1; m_st = 2'd0;
                end
            end else if (k == 4'hA || k == 4'hB) begin
                m_opc = (k == 4'hA) ? 3'b000 : 3'b010;
                if (m_st == 2'd0) begin
                    m_op2 = 8'h00; m_cnt = 0; m_st = 2'd1;
                end else if (m_st == 2'd2) begin
                    m_op1 = m_res; m_op2 = 8'h00; m_cnt = 0; m_st = 2'd1;
                end
            end else if (k == 4'hC && m_st == 2'd1) begin
                m_res = alu_result; m_car = alu_carry; m_st = 2'd2;
            end
        end
    endtask

    function automatic snap_t m_snap();
        snap_t s;
        s.op1  = m_op1;
        s.op2  = m_op2;
        s.opc  = m_opc;
        s.res  = m_res;
        s.car  = m_car;
        s.rv   = (m_st == 2'd2);
        s.st   = m_st;
        s.disp = (m_st == 2'd0) ? m_op1 : (m_st == 2'd1) ? m_op2 : m_res;
        return s;
    endfunction

    task automatic drive(input logic r, input logic kv, input logic [3:0] k);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = k; apply = 1'b1;
        m_step(r, kv, k);
        sb.push_back(m_snap());
        @(posedge clk);
        #1;
        rst = 1'b0; key_valid = 1'b0; apply = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        drive(1'b0, 1'b1, k);
    endtask

    always @(posedge clk) pend <= apply;

    // Output side of the scoreboard: one expected snapshot per applied cycle.
    always @(negedge clk) begin
        if (pend) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_s = sb.pop_front();
                check("op1",          op1,          exp_s.op1);
                check("op2",          op2,          exp_s.op2);
                check("opcode",       opcode,       exp_s.opc);
                check("result",       result,       exp_s.res);
                check("carry",        carry,        exp_s.car);
                check("result_valid", result_valid, exp_s.rv);
                check("display",      display,      exp_s.disp);
                check("state",        state,        exp_s.st);
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, 4'h0);
        check("rst_display", display, 8'h00);

        // Basic add
        key(4'h4); key(4'h2); key(4'hA); key(4'h1); key(4'h7);
        alu_result = 8'h59; alu_carry = 1'b0;
        key(4'hC);
        check("t1_op1", op1, 8'h42);
        check("t1_op2", op2, 8'h17);
        check("t1_opcode", opcode, 3'b000);
        check("t1_result", result, 8'h59);
        check("t1_rv", result_valid, 1'b1);

        // Chaining from the previous result
        key(4'hB); key(4'h0); key(4'h9);
        alu_result = 8'h50;
        key(4'hC);
        check("t3_op1", op1, 8'h59);
        check("t3_opcode", opcode, 3'b010);
        check("t3_op2", op2, 8'h09);
        check("t3_result", result, 8'h50);
        key(4'h7);
        check("t3_state", state, 2'd0);
        check("t3_op1_new", op1, 8'h07);
        check("t3_op2_new", op2, 8'h00);

        // Ignored keys in S_OP1 and an idle cycle carrying a digit code
        key(4'hE); key(4'hC); key(4'hF);
        drive(1'b0, 1'b0, 4'h3);
        check("t6_op1", op1, 8'h07);

        // Digit limit and operator replacement
        key(4'hD);
        key(4'h1); key(4'h2); key(4'h3); key(4'hB); key(4'hA); key(4'h5);
        check("t2_op1", op1, 8'h12);
        check("t2_opcode", opcode, 3'b000);
        check("t2_op2", op2, 8'h05);
        check("t2_display", display, 8'h05);
        key(4'hE); key(4'hF);

        // Clear mid-S_OP2
        key(4'hD);
        check("t5_state", state, 2'd0);
        check("t5_op1", op1, 8'h00);
        check("t5_op2", op2, 8'h00);

        // Overflow capture, operator change with op2 partially entered
        key(4'h9); key(4'h9); key(4'hA); key(4'h0); key(4'hB); key(4'hA); key(4'h1);
        check("t4_op2", op2, 8'h01);
        alu_result = 8'h00; alu_carry = 1'b1;
        key(4'hC);
        check("t4_result", result, 8'h00);
        check("t4_carry", carry, 1'b1);
        alu_result = 8'h77; alu_carry = 1'b0;
        key(4'hC); key(4'hE); key(4'hF);
        check("t6_result_hold", result, 8'h00);

        // Reset wins over a coincident digit key
        drive(1'b1, 1'b1, 4'h5);
        check("t5_rst_op1", op1, 8'h00);

        // Random key stream with random ALU stub values
        for (int i = 0; i < 400; i++) begin
            logic [3:0] k;
            k = 4'($urandom_range(0, 15));
            alu_result = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            alu_carry  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                drive(1'b1, 1'($urandom_range(0, 1)), k);
            else if ($urandom_range(0, 9) == 0)
                drive(1'b0, 1'b0, k);
            else
                key(k);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
